// File: rtl/mult_div.sv
// Sequential 32-bit signed multiply (radix-2 Booth) and divide (restoring on magnitudes).
// One iteration per clock; hi/lo update only on completion.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned Width    = 32;
  localparam int unsigned AccWidth = Width + 2;
  localparam int unsigned CntWidth = 5;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state, stateNext;
  logic [CntWidth-1:0] cnt, cntNext;
  logic                opReg, opNext;
  logic [Width-1:0]    aReg, aNext;
  logic [Width-1:0]    bReg, bNext;
  logic [AccWidth-1:0] hiAcc, hiAccNext;
  logic [Width-1:0]    loAcc, loAccNext;
  logic                qm1, qm1Next;
  logic [Width-1:0]    hiNext, loNext;
  logic                busyNext, doneNext, divZeroNext;

  logic [Width-1:0]    aAbsIn;
  logic [Width-1:0]    absB;
  logic [AccWidth-1:0] aExt;
  logic [AccWidth-1:0] mSum;
  logic [AccWidth-1:0] mHiNew;
  logic [Width-1:0]    mLoNew;
  logic [Width-1:0]    dShift;
  logic [Width:0]      dDiff;
  logic [Width-1:0]    dRem;
  logic [Width-1:0]    dQuo;
  logic [Width-1:0]    divQ;
  logic [Width-1:0]    divR;

  // Datapath for one Booth step and one restoring-division step.
  always_comb begin
    aAbsIn = a[Width-1] ? (Width'(0) - a) : a;
    absB   = bReg[Width-1] ? (Width'(0) - bReg) : bReg;
    aExt   = {{2{aReg[Width-1]}}, aReg};

    mSum = hiAcc;
    case ({loAcc[0], qm1})
      2'b01:   mSum = hiAcc + aExt;
      2'b10:   mSum = hiAcc - aExt;
      default: mSum = hiAcc;
    endcase
    mHiNew = {mSum[AccWidth-1], mSum[AccWidth-1:1]};
    mLoNew = {mSum[0], loAcc[Width-1:1]};

    // Partial remainder is always below |b| <= 2^31, so its top bit is zero.
    dShift = {hiAcc[Width-2:0], loAcc[Width-1]};
    dDiff  = {1'b0, dShift} - {1'b0, absB};
    if (!dDiff[Width]) begin
      dRem = dDiff[Width-1:0];
      dQuo = {loAcc[Width-2:0], 1'b1};
    end else begin
      dRem = dShift;
      dQuo = {loAcc[Width-2:0], 1'b0};
    end

    divQ = (aReg[Width-1] ^ bReg[Width-1]) ? (Width'(0) - dQuo) : dQuo;
    divR = aReg[Width-1] ? (Width'(0) - dRem) : dRem;
  end

  // Next-state and registered-output logic.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    opNext      = opReg;
    aNext       = aReg;
    bNext       = bReg;
    hiAccNext   = hiAcc;
    loAccNext   = loAcc;
    qm1Next     = qm1;
    hiNext      = hi;
    loNext      = lo;
    divZeroNext = div_zero;

    case (state)
      StIdle: begin
        if (start) begin
          opNext      = op;
          aNext       = a;
          bNext       = b;
          cntNext     = CntWidth'(31);
          divZeroNext = 1'b0;
          qm1Next     = 1'b0;
          hiAccNext   = '0;
          loAccNext   = op ? aAbsIn : b;
          if (op && (b == '0)) begin
            stateNext   = StDone;
            divZeroNext = 1'b1;
          end else begin
            stateNext = StRun;
          end
        end
      end
      StRun: begin
        cntNext = cnt - CntWidth'(1);
        if (!opReg) begin
          hiAccNext = mHiNew;
          loAccNext = mLoNew;
          qm1Next   = loAcc[0];
        end else begin
          hiAccNext = {2'b00, dRem};
          loAccNext = dQuo;
        end
        if (cnt == '0) begin
          stateNext = StDone;
          hiNext    = opReg ? divR : mHiNew[Width-1:0];
          loNext    = opReg ? divQ : mLoNew;
        end
      end
      StDone: begin
        stateNext = StIdle;
      end
      default: begin
        stateNext = StIdle;
      end
    endcase

    busyNext = (stateNext == StRun);
    doneNext = (stateNext == StDone);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      cnt      <= '0;
      opReg    <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      hiAcc    <= '0;
      loAcc    <= '0;
      qm1      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      opReg    <= opNext;
      aReg     <= aNext;
      bReg     <= bNext;
      hiAcc    <= hiAccNext;
      loAcc    <= loAccNext;
      qm1      <= qm1Next;
      hi       <= hiNext;
      lo       <= loNext;
      busy     <= busyNext;
      done     <= doneNext;
      div_zero <= divZeroNext;
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: random and directed MULT/DIV against a 64-bit arithmetic model.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h expected=%h", nm, got, exp);
  endtask

  // Reference: exact signed arithmetic, truncating division, remainder follows dividend.
  task automatic pushExpect(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint xa, ya, p, q, r;
    xa = longint'($signed(x));
    ya = longint'($signed(y));
    if (!o) begin
      p    = xa * ya;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (y == 32'd0) begin
      e.hi = lastHi;
      e.lo = lastLo;
      e.dz = 1'b1;
    end else begin
      q    = xa / ya;
      r    = xa % ya;
      e.hi = r[31:0];
      e.lo = q[31:0];
      e.dz = 1'b0;
    end
    lastHi = e.hi;
    lastLo = e.lo;
    sb.push_back(e);
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("unexpectedDone", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("divZero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  // Issue one operation; optionally poke start mid-RUN and during DONE.
  task automatic runOp(input logic o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    int          cyc, busyCnt;
    bit          held, sawDone, dz;
    logic [31:0] h0, l0;
    dz = o && (y == 32'd0);
    @(negedge clock);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    pushExpect(o, x, y);
    @(posedge clock); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    cyc = 1; busyCnt = 0; held = 1'b1; sawDone = 1'b0;
    while (cyc < 40) begin
      @(negedge clock);
      start = 1'b0;
      if (busy) busyCnt++;
      if (done) begin
        sawDone = 1'b1;
        start   = poke;
        break;
      end
      if (hi !== h0 || lo !== l0) held = 1'b0;
      start = poke && (cyc == 10);
      @(posedge clock);
      cyc++;
    end
    check("doneLatency", 64'(sawDone ? cyc : 0), 64'(dz ? 1 : 33));
    check("busyCycles", 64'(busyCnt), 64'(dz ? 0 : 32));
    check("holdDuringRun", 64'(held), 64'(1));
    @(negedge clock);
    start = 1'b0;
    check("idleAfterDone", 64'({busy, done}), 64'(0));
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] ex[5];
    ex[0] = 32'h8000_0000; ex[1] = 32'h7FFF_FFFF; ex[2] = 32'hFFFF_FFFF;
    ex[3] = 32'h0000_0000; ex[4] = 32'h0000_0001;
    case ($urandom_range(0, 3))
      0:       return ex[$urandom_range(0, 4)];
      1:       return 32'($signed(8'($urandom)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  waitCnt;
    bit  noDone;
    repeat (3) @(negedge clock);
    check("rstHi", 64'(hi), 64'(0));
    check("rstLo", 64'(lo), 64'(0));
    check("rstCtl", 64'({busy, done, div_zero}), 64'(0));
    reset = 1'b1;

    runOp(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mul7x-3", 64'({hi, lo}), 64'h FFFF_FFFF_FFFF_FFEB);
    runOp(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mulMinMin", 64'({hi, lo}), 64'h4000_0000_0000_0000);
    runOp(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div-7by2", 64'({hi, lo}), 64'h FFFF_FFFF_FFFF_FFFD);
    runOp(1'b1, 32'd5, 32'd0, 1'b1);
    check("divZeroKeep", 64'({hi, lo}), 64'h FFFF_FFFF_FFFF_FFFD);
    runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("divMinByM1", 64'({hi, lo}), 64'h0000_0000_8000_0000);

    for (int i = 0; i < 40; i++)
      runOp(1'($urandom), pickOperand(), pickOperand(), bit'($urandom_range(0, 1)));

    // Abort a MULT with reset part-way through.
    runOp(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    check("busyMidRun", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("abortHiLo", 64'({hi, lo}), 64'(0));
    check("abortCtl", 64'({busy, done, div_zero}), 64'(0));
    lastHi = '0; lastLo = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    noDone = 1'b1;
    for (waitCnt = 0; waitCnt < 40; waitCnt++) begin
      @(negedge clock);
      if (done || busy) noDone = 1'b0;
    end
    check("noDoneAfterReset", 64'(noDone), 64'(1));
    runOp(1'b0, 32'd3, 32'd4, 1'b0);
    check("mul3x4", 64'({hi, lo}), 64'h0000_0000_0000_000C);

    repeat (2) @(negedge clock);
    check("scoreboardDrained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
